// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : shared types and helpers for the UART byte receiver.
//            UART_RX_PARITY_EN adds the PARITY state to the state enum.
// Revision : 1.0
// ============================================================================
package uart_pkg;

   localparam int UART_DATA_BITS = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4,
      ST_BREAK  = 3'd5
   } uart_rx_state_t;

   // High when data plus parity bit do not hold an even number of ones.
   function automatic logic parity_mismatch(input logic [UART_DATA_BITS-1:0] i_data,
                                            input logic                      i_par_bit);
      return (^i_data) ^ i_par_bit;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ============================================================================
// uart_sync2 : two-flop synchronizer with a configurable reset value.
// Revision   : 1.0
// ============================================================================
module uart_sync2 #(
   parameter logic RESET_VALUE = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_meta <= RESET_VALUE;
         r_sync <= RESET_VALUE;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_byte_rx.sv
`default_nettype none
// ============================================================================
// uart_byte_rx : mid-bit sampling UART byte receiver, 8N1 by default,
//                8E1 when UART_RX_PARITY_EN is defined.
// Revision     : 1.0
// ============================================================================
module uart_byte_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rxd,
   output logic       out_valid,
   output logic [7:0] out_byte,
   output logic       frame_err,
   output logic       parity_err
);

   localparam int                 CNT_W      = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]   c_half_bit = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0]   c_full_bit = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]         c_last_idx = 3'(UART_DATA_BITS - 1);

   logic                      w_rxd_s;
   logic                      w_sample;

   uart_rx_state_t            r_state;
   uart_rx_state_t            w_state_nxt;
   logic [CNT_W-1:0]          r_cnt;
   logic [CNT_W-1:0]          w_cnt_nxt;
   logic [2:0]                r_idx;
   logic [2:0]                w_idx_nxt;
   logic [UART_DATA_BITS-1:0] r_shift;
   logic [UART_DATA_BITS-1:0] w_shift_nxt;

   logic                      w_valid;
   logic                      w_ferr;
   logic                      r_out_valid;
   logic [7:0]                r_out_byte;
   logic                      r_frame_err;

`ifdef UART_RX_PARITY_EN
   logic                      r_par_bad;
   logic                      w_par_bad_nxt;
   logic                      w_perr;
   logic                      r_parity_err;
`endif

   uart_sync2 #(
      .RESET_VALUE (1'b1)
   ) u_rxd_sync (
      .clk   (clk),
      .reset (reset),
      .i_d   (rxd),
      .o_q   (w_rxd_s)
   );

   assign w_sample = (r_cnt == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_idx        <= '0;
         r_shift      <= '0;
         r_out_valid  <= 1'b0;
         r_out_byte   <= 8'h00;
         r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_bad    <= 1'b0;
         r_parity_err <= 1'b0;
`endif
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_idx        <= w_idx_nxt;
         r_shift      <= w_shift_nxt;
         r_out_valid  <= w_valid;
         r_frame_err  <= w_ferr;
         if (w_valid) begin
            r_out_byte <= r_shift;
         end
`ifdef UART_RX_PARITY_EN
         r_par_bad    <= w_par_bad_nxt;
         r_parity_err <= w_perr;
`endif
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_idx_nxt     = r_idx;
      w_shift_nxt   = r_shift;
      w_valid       = 1'b0;
      w_ferr        = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_par_bad_nxt = r_par_bad;
      w_perr        = 1'b0;
`endif

      case (r_state)
         ST_IDLE: begin
            if (!w_rxd_s) begin
               w_state_nxt = ST_START;
               w_cnt_nxt   = c_half_bit;
            end
         end

         // A start bit that is high again at mid-bit is treated as a glitch.
         ST_START: begin
            if (!w_sample) begin
               w_cnt_nxt = r_cnt - 1'b1;
            end else if (w_rxd_s) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt   = ST_DATA;
               w_cnt_nxt     = c_full_bit;
               w_idx_nxt     = '0;
`ifdef UART_RX_PARITY_EN
               w_par_bad_nxt = 1'b0;
`endif
            end
         end

         ST_DATA: begin
            if (!w_sample) begin
               w_cnt_nxt = r_cnt - 1'b1;
            end else begin
               w_cnt_nxt   = c_full_bit;
               w_shift_nxt = {w_rxd_s, r_shift[UART_DATA_BITS-1:1]};
               if (r_idx == c_last_idx) begin
`ifdef UART_RX_PARITY_EN
                  w_state_nxt = ST_PARITY;
`else
                  w_state_nxt = ST_STOP;
`endif
               end else begin
                  w_idx_nxt = r_idx + 3'd1;
               end
            end
         end

`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (!w_sample) begin
               w_cnt_nxt = r_cnt - 1'b1;
            end else begin
               w_cnt_nxt     = c_full_bit;
               w_par_bad_nxt = parity_mismatch(r_shift, w_rxd_s);
               w_state_nxt   = ST_STOP;
            end
         end
`endif

         // A low stop bit wins over any parity mismatch in the same frame.
         ST_STOP: begin
            if (!w_sample) begin
               w_cnt_nxt = r_cnt - 1'b1;
            end else if (w_rxd_s) begin
               w_state_nxt = ST_IDLE;
`ifdef UART_RX_PARITY_EN
               if (r_par_bad) begin
                  w_perr = 1'b1;
               end else begin
                  w_valid = 1'b1;
               end
`else
               w_valid = 1'b1;
`endif
            end else begin
               w_state_nxt = ST_BREAK;
               w_ferr      = 1'b1;
            end
         end

         ST_BREAK: begin
            if (w_rxd_s) begin
               w_state_nxt = ST_IDLE;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign out_valid = r_out_valid;
   assign out_byte  = r_out_byte;
   assign frame_err = r_frame_err;
`ifdef UART_RX_PARITY_EN
   assign parity_err = r_parity_err;
`else
   assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_byte_rx.sv
`default_nettype none
// ============================================================================
// tb_uart_byte_rx : scoreboard bench for uart_byte_rx at 16 and 4 clocks/bit.
// Revision        : 1.0
// ============================================================================
module tb_uart_byte_rx;

`ifdef UART_RX_PARITY_EN
   localparam int NB = 10;
`else
   localparam int NB = 9;
`endif

   typedef struct {
      logic [7:0] b;
      int         start;
   } exp_t;

   logic       clk    = 1'b0;
   logic       reset  = 1'b0;
   logic       rxd16  = 1'b1;
   logic       rxd4   = 1'b1;
   logic       ov16, fe16, pe16, ov4, fe4, pe4;
   logic [7:0] ob16, ob4;

   int cyc     = 0;
   int n_total = 0;
   int n_pass  = 0;
   int nv16 = 0, nf16 = 0, np16 = 0, nv4 = 0;
   logic pv16 = 1'b0, pf16 = 1'b0, pp16 = 1'b0, pv4 = 1'b0;
   exp_t sb16[$];
   exp_t sb4[$];
`ifdef UART_RX_PARITY_EN
   bit flip_parity = 1'b0;
`endif

   uart_byte_rx #(.CLKS_PER_BIT(16)) u_dut16 (
      .clk(clk), .reset(reset), .rxd(rxd16),
      .out_valid(ov16), .out_byte(ob16), .frame_err(fe16), .parity_err(pe16)
   );

   uart_byte_rx #(.CLKS_PER_BIT(4)) u_dut4 (
      .clk(clk), .reset(reset), .rxd(rxd4),
      .out_valid(ov4), .out_byte(ob4), .frame_err(fe4), .parity_err(pe4)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Start edge to out_valid: start + data (+ parity) bits, half the stop bit, 3 cycles.
   function automatic int lat(input int cpb);
      return NB * cpb + cpb / 2 + 3;
   endfunction

   always @(negedge clk) begin : mon
      exp_t e;
      if (ov16) begin
         nv16++;
         n_total++;
         if (sb16.size() == 0) begin
            $display("FAIL sb16_unexpected: got byte %h, no byte expected", ob16);
         end else begin
            e = sb16.pop_front();
            if (ob16 !== e.b || (cyc - e.start) != lat(16))
               $display("FAIL sb16_byte: got %h after %0d cycles, want %h after %0d",
                        ob16, cyc - e.start, e.b, lat(16));
            else n_pass++;
         end
         n_total++;
         if (pv16 !== 1'b0 || fe16 !== 1'b0 || pe16 !== 1'b0)
            $display("FAIL valid16_shape: prev=%b ferr=%b perr=%b, want 0 0 0", pv16, fe16, pe16);
         else n_pass++;
      end
      if (fe16) begin
         nf16++;
         n_total++;
         if (pf16 !== 1'b0 || pe16 !== 1'b0)
            $display("FAIL ferr16_shape: prev=%b perr=%b, want 0 0", pf16, pe16);
         else n_pass++;
      end
      if (pe16) begin
         np16++;
         n_total++;
         if (pp16 !== 1'b0)
            $display("FAIL perr16_shape: prev=%b, want 0", pp16);
         else n_pass++;
      end
      if (ov4) begin
         nv4++;
         n_total++;
         if (sb4.size() == 0) begin
            $display("FAIL sb4_unexpected: got byte %h, no byte expected", ob4);
         end else begin
            e = sb4.pop_front();
            if (ob4 !== e.b || (cyc - e.start) != lat(4) || pv4 !== 1'b0)
               $display("FAIL sb4_byte: got %h after %0d cycles prev=%b, want %h after %0d",
                        ob4, cyc - e.start, pv4, e.b, lat(4));
            else n_pass++;
         end
      end
      pv16 <= ov16;
      pf16 <= fe16;
      pp16 <= pe16;
      pv4  <= ov4;
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input bit sel4, input logic v, input int cycles);
      if (sel4) rxd4 = v;
      else      rxd16 = v;
      idle(cycles);
   endtask

   task automatic send_frame(input bit sel4, input logic [7:0] b, input logic stop, input bit expect_ok);
      int   cpb;
      exp_t e;
      cpb = sel4 ? 4 : 16;
      if (expect_ok) begin
         e.b     = b;
         e.start = cyc;
         if (sel4) sb4.push_back(e);
         else      sb16.push_back(e);
      end
      drive_bit(sel4, 1'b0, cpb);
      for (int i = 0; i < 8; i++) drive_bit(sel4, b[i], cpb);
`ifdef UART_RX_PARITY_EN
      drive_bit(sel4, (^b) ^ flip_parity, cpb);
`endif
      drive_bit(sel4, stop, cpb);
   endtask

   task automatic test_reset;
      reset = 1'b0;
      idle(3);
      n_total++;
      if (ov16 !== 1'b0 || fe16 !== 1'b0 || pe16 !== 1'b0 || ob16 !== 8'h00)
         $display("FAIL reset16: valid=%b ferr=%b perr=%b byte=%h, want 0 0 0 00", ov16, fe16, pe16, ob16);
      else n_pass++;
      n_total++;
      if (ov4 !== 1'b0 || ob4 !== 8'h00)
         $display("FAIL reset4: valid=%b byte=%h, want 0 00", ov4, ob4);
      else n_pass++;
      reset = 1'b1;
      idle(4);
   endtask

   task automatic test_back_to_back;
      int v0;
      v0 = nv16;
      send_frame(1'b0, 8'h55, 1'b1, 1'b1);
      send_frame(1'b0, 8'hA3, 1'b1, 1'b1);
      idle(20);
      n_total++;
      if (nv16 - v0 != 2 || sb16.size() != 0 || ob16 !== 8'hA3)
         $display("FAIL back_to_back: pulses=%0d pending=%0d byte=%h, want 2 0 a3", nv16 - v0, sb16.size(), ob16);
      else n_pass++;
   endtask

   task automatic test_glitch;
      int v0, f0, p0;
      v0 = nv16; f0 = nf16; p0 = np16;
      drive_bit(1'b0, 1'b0, 5);
      drive_bit(1'b0, 1'b1, 30);
      n_total++;
      if (nv16 != v0 || nf16 != f0 || np16 != p0 || ob16 !== 8'hA3)
         $display("FAIL glitch: pulses v/f/p=%0d/%0d/%0d byte=%h, want 0/0/0 a3",
                  nv16 - v0, nf16 - f0, np16 - p0, ob16);
      else n_pass++;
      send_frame(1'b0, 8'h7E, 1'b1, 1'b1);
      idle(20);
      n_total++;
      if (nv16 - v0 != 1 || sb16.size() != 0 || ob16 !== 8'h7E)
         $display("FAIL after_glitch: pulses=%0d byte=%h, want 1 7e", nv16 - v0, ob16);
      else n_pass++;
   endtask

   task automatic test_frame_err;
      int v0, f0;
      v0 = nv16; f0 = nf16;
      send_frame(1'b0, 8'h41, 1'b0, 1'b0);
      drive_bit(1'b0, 1'b0, 40);
      n_total++;
      if (nf16 - f0 != 1 || nv16 != v0 || ob16 !== 8'h7E)
         $display("FAIL frame_err: ferr=%0d valid=%0d byte=%h, want 1 0 7e", nf16 - f0, nv16 - v0, ob16);
      else n_pass++;
      drive_bit(1'b0, 1'b1, 16);
      send_frame(1'b0, 8'h42, 1'b1, 1'b1);
      idle(20);
      n_total++;
      if (nf16 - f0 != 1 || nv16 - v0 != 1 || ob16 !== 8'h42)
         $display("FAIL after_break: ferr=%0d valid=%0d byte=%h, want 1 1 42", nf16 - f0, nv16 - v0, ob16);
      else n_pass++;
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity;
      int v0, p0;
      v0 = nv16; p0 = np16;
      flip_parity = 1'b1;
      send_frame(1'b0, 8'h07, 1'b1, 1'b0);
      flip_parity = 1'b0;
      idle(20);
      n_total++;
      if (np16 - p0 != 1 || nv16 != v0 || ob16 !== 8'h42)
         $display("FAIL parity_bad: perr=%0d valid=%0d byte=%h, want 1 0 42", np16 - p0, nv16 - v0, ob16);
      else n_pass++;
      send_frame(1'b0, 8'h07, 1'b1, 1'b1);
      idle(20);
      n_total++;
      if (np16 - p0 != 1 || nv16 - v0 != 1 || ob16 !== 8'h07)
         $display("FAIL parity_good: perr=%0d valid=%0d byte=%h, want 1 1 07", np16 - p0, nv16 - v0, ob16);
      else n_pass++;
   endtask
`endif

   task automatic test_reset_abort;
      int v0, f0;
      v0 = nv16; f0 = nf16;
      drive_bit(1'b0, 1'b0, 16);
      drive_bit(1'b0, 1'b1, 3 * 16 + 8);
      reset = 1'b0;
      #1;
      n_total++;
      if (ob16 !== 8'h00 || ov16 !== 1'b0)
         $display("FAIL abort_in_reset: byte=%h valid=%b, want 00 0", ob16, ov16);
      else n_pass++;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      drive_bit(1'b0, 1'b1, 16 * 8);
      n_total++;
      if (ob16 !== 8'h00 || nv16 != v0 || nf16 != f0)
         $display("FAIL abort_after: byte=%h valid=%0d ferr=%0d, want 00 0 0", ob16, nv16 - v0, nf16 - f0);
      else n_pass++;
      send_frame(1'b0, 8'h12, 1'b1, 1'b1);
      idle(20);
      n_total++;
      if (nv16 - v0 != 1 || sb16.size() != 0 || ob16 !== 8'h12)
         $display("FAIL abort_next: pulses=%0d byte=%h, want 1 12", nv16 - v0, ob16);
      else n_pass++;
   endtask

   task automatic test_cpb4;
      int v0;
      v0 = nv4;
      send_frame(1'b1, 8'h00, 1'b1, 1'b1);
      send_frame(1'b1, 8'hFF, 1'b1, 1'b1);
      idle(12);
      n_total++;
      if (nv4 - v0 != 2 || sb4.size() != 0 || ob4 !== 8'hFF)
         $display("FAIL cpb4: pulses=%0d pending=%0d byte=%h, want 2 0 ff", nv4 - v0, sb4.size(), ob4);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_glitch();
      test_frame_err();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      test_reset_abort();
      test_cpb4();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_byte_rx.md
UART_BYTE_RX -- requirements
Module: uart_byte_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; legal range 4..65535.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset (0 = in reset).
REQ-004 SHALL have port rxd, input, 1, asynchronous serial line, idle high, 8N1 framing (8E1 when parity enabled).
REQ-005 SHALL have port out_valid, output, 1, one-cycle pulse marking a good received byte; drives a byte printer's in_valid directly.
REQ-006 SHALL have port out_byte, output, 8, received byte; held stable until the next good byte.
REQ-007 SHALL have port frame_err, output, 1, one-cycle pulse on a bad stop bit.
REQ-008 SHALL have port parity_err, output, 1, one-cycle pulse on a parity mismatch.

Function
REQ-009 SHALL pass rxd through a 2-flop synchronizer (reset value 1) before any use; all timing below is relative to the synchronized signal rxd_s.
REQ-010 SHALL implement an FSM with states IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-011 IDLE: on rxd_s==0, load the bit counter with CLKS_PER_BIT/2-1 (integer divide) and go to START.
REQ-012 START: at counter expiry, sample rxd_s. If 1 (glitch), go to IDLE with no output. If 0, go to DATA with a bit index of 0.
REQ-013 Every subsequent sample SHALL occur CLKS_PER_BIT cycles after the previous one (mid-bit); the counter reloads with CLKS_PER_BIT-1 at each sample.
REQ-014 DATA: shift in 8 samples LSB first. After index 7, go to PARITY if enabled, else STOP.
REQ-015 PARITY: sample one bit and latch a mismatch flag (even parity over the 8 data bits plus the parity bit). Then go to STOP.
REQ-016 STOP, sample 1 and no parity mismatch: register the byte to out_byte, pulse out_valid the cycle after the sample, and go to IDLE.
REQ-017 STOP, sample 1 with a parity mismatch: pulse parity_err, leave out_valid low and out_byte unchanged, and go to IDLE.
REQ-018 STOP, sample 0: pulse frame_err, leave out_valid low and out_byte unchanged, and go to BREAK; a parity mismatch in the same frame is suppressed.
REQ-019 BREAK: remain there until rxd_s==1, then go to IDLE; no new start bit is recognised while rxd_s stays low.
REQ-020 out_valid, frame_err and parity_err SHALL be mutually exclusive and at most one cycle wide per frame.
REQ-021 The block SHALL have no backpressure; a consumer must accept a byte in the out_valid cycle.
REQ-022 Back-to-back frames SHALL be received with zero idle bits: the start bit may fall in the cycle after the stop sample.
REQ-023 The counter width SHALL be $clog2(CLKS_PER_BIT) bits, with no wrap beyond CLKS_PER_BIT-1.

Reset
REQ-024 While reset==0: FSM=IDLE, counters=0, synchronizer=1, out_byte=8'h00, out_valid=frame_err=parity_err=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no output pulse. After release, the receiver waits for a fresh falling edge.
REQ-026 Reset release SHALL be synchronized externally. The block does not stretch reset.

Configuration
REQ-027 Macro UART_RX_PARITY_EN defined: the PARITY state exists and frames are 11 bits (start, 8 data, even parity, stop).
REQ-028 Macro UART_RX_PARITY_EN undefined: the PARITY state and its logic are compiled out, frames are 10 bits, and parity_err is tied to 0.

Structure
REQ-029 A shared package uart_pkg SHALL hold the FSM state enum (uart_rx_state_t), UART_DATA_BITS=8, and the parity helper function.
REQ-030 One sub-module, uart_sync2 (2-flop synchronizer with reset value parameter), SHALL be instantiated for rxd. The rest is flat.

Verification (CLKS_PER_BIT=16, bit period 16 clk)
REQ-031 Send 0x55 then 0xA3 back-to-back, no idle between -> two out_valid pulses with out_byte 0x55 then 0xA3, each 1 cycle wide, the first ~9.5 bit periods plus 3 cycles after the first start edge.
REQ-032 Drive rxd low for 5 cycles, then high -> no pulses, FSM back in IDLE; a following 0x7E frame is received correctly.
REQ-033 Send 0x41 with the stop bit low, then hold rxd low for 40 cycles, then high, then send 0x42 -> one frame_err pulse, no out_valid for 0x41, out_byte keeps its prior value, then out_valid with 0x42.
REQ-034 With UART_RX_PARITY_EN, send 0x07 with parity bit 0 -> one parity_err pulse and no out_valid. Send 0x07 with parity bit 1 -> out_valid with 0x07.
REQ-035 Assert reset in the middle of the 4th data bit of 0xFF, release after 3 cycles, then send 0x12 -> no pulse for the aborted frame, out_byte=0x00 during and after reset, then out_valid with 0x12.
REQ-036 Send 0x00 then 0xFF with CLKS_PER_BIT=4 -> both bytes received. Check that sampling falls on cycle 2 of each 4-cycle bit.
